dma_rd_stream: RTL and testbench
================================

DMA_RD_STREAM -- requirements
Module: dma_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, read data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter SIZE_WIDTH, default 16, transfer length width in words.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit (used only with REQ-030).
REQ-005 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a transfer.
- addr  in  ADDR_WIDTH  offset sampled on start.
- size  in  SIZE_WIDTH  word count sampled on start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky abort flag.
- rd_go  out  1  one-cycle read request to the DMA controller.
- rd_addr  out  ADDR_WIDTH  latched offset.
- rd_size  out  SIZE_WIDTH  latched count.
- rd_data  in  DATA_WIDTH  show-ahead head word, valid while empty=0.
- empty  in  1  controller read FIFO empty.
- rd_en  out  1  pops one word.
- rd_done  in  1  controller read-complete pulse.
- m_valid  out  1  output stream valid.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  marks final word.
- m_ready  in  1  downstream accept.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, STREAM, WAIT_DONE, FIN.
REQ-007 IDLE: on start with size!=0, SHALL latch addr/size into rd_addr/rd_size, clear err, go to REQ. With size==0, SHALL go to FIN, no rd_go.
REQ-008 REQ SHALL assert rd_go for exactly one cycle, then go to STREAM.
REQ-009 rd_addr/rd_size SHALL hold stable from REQ until return to IDLE.
REQ-010 start SHALL be ignored whenever busy=1; busy=1 in every state except IDLE.
REQ-011 STREAM: rd_en = !empty && (remaining!=0) && (!m_valid || m_ready), combinational.
REQ-012 On rd_en, m_data SHALL load rd_data and m_valid SHALL set next cycle; remaining SHALL decrement by 1.
REQ-013 m_valid SHALL clear after m_valid&&m_ready unless reloaded the same cycle; m_data SHALL hold while m_valid&&!m_ready.
REQ-014 m_last SHALL be 1 exactly with the word loaded when remaining==1.
REQ-015 rd_done SHALL be captured in a sticky flag at any point from REQ onward.
REQ-016 After the m_last handshake: go to FIN if the flag is set, else WAIT_DONE until rd_done.
REQ-017 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-018 Sustained throughput SHALL be one word per cycle with m_ready=1 and empty=0.
REQ-019 Remaining counter SHALL be SIZE_WIDTH bits; size all-ones SHALL transfer 2^SIZE_WIDTH-1 words with no wrap.

Reset
REQ-020 rst_n low SHALL force IDLE and zero all outputs and internal registers, mid-transfer included; no done pulse.
REQ-021 Words left in the controller FIFO after a mid-transfer reset SHALL NOT be popped.

Configuration
REQ-030 With DMA_RD_STREAM_TIMEOUT_EN defined: in STREAM or WAIT_DONE, TIMEOUT_CYCLES consecutive cycles with no rd_en, no rd_done, and no stalled m_valid SHALL set err, drop m_valid, go to FIN. Without it: no watchdog, err tied 0.

Structure
REQ-040 Package dma_pkg SHALL hold the state enum typedef and default width constants.
REQ-041 Single module; no sub-module.

Verification
REQ-050 start, addr=0x100, size=4, empty=0, m_ready=1, rd_done 2 cycles after last pop -> one rd_go, 4 words back-to-back, m_last on 4th, done once.
REQ-051 size=3, m_ready toggles 1/0 each cycle -> m_data stable while stalled, no word lost or duplicated, rd_en never while stalled.
REQ-052 size=0 -> no rd_go, no rd_en, done 2 cycles after start.
REQ-053 rd_done before last word, size=2 -> FIN right after m_last handshake, no WAIT_DONE.
REQ-054 rst_n low after 2 of 8 words -> all outputs 0 next edge, no done, no further rd_en.
REQ-055 Macro set, TIMEOUT_CYCLES=16, empty held 1 -> err=1 and done at cycle 16, err clears on next start.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared state encoding and default widths for the DMA read-to-stream adapter.
package dma_pkg;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_SIZE_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_WAIT_DONE,
    S_FIN
  } state_t;
endpackage

// File: rtl/dma_rd_stream.sv
// Issues one DMA read request, then drains the controller's show-ahead FIFO into a valid/ready stream.
// Optional stall watchdog is compiled in with DMA_RD_STREAM_TIMEOUT_EN.
module dma_rd_stream
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int SIZE_WIDTH     = DEF_SIZE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_go,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [SIZE_WIDTH-1:0] rd_size,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic                  rd_done,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [SIZE_WIDTH-1:0]   remain_q, remain_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    flag_q, flag_d;
  logic                    active, pop, last_hs, launch, timeout_hit;

  // Handshake: a word moves downstream in any cycle with m_valid && m_ready;
  // m_data/m_last are held unchanged while m_valid && !m_ready.
  assign active  = (state_q == S_STREAM) || (state_q == S_WAIT_DONE);
  assign pop     = (state_q == S_STREAM) && !empty && (remain_q != '0) && (!valid_q || m_ready);
  assign last_hs = valid_q && m_ready && last_q;
  assign launch  = (state_q == S_IDLE) && start && (size != '0);

`ifdef DMA_RD_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] quiet_q, quiet_d;
  logic          err_q, err_d, quiet;

  // A stalled downstream is not a stall of the read path, so it keeps the watchdog quiet.
  assign quiet       = active && !pop && !rd_done && !(valid_q && !m_ready);
  assign timeout_hit = quiet && (quiet_q == TW'(TIMEOUT_CYCLES - 1));
  assign quiet_d     = quiet ? quiet_q + 1'b1 : '0;

  always_comb begin
    err_d = err_q;
    if (launch)      err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quiet_q <= '0;
      err_q   <= 1'b0;
    end else begin
      quiet_q <= quiet_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = (size != '0) ? S_REQ : S_FIN;
      S_REQ:       state_d = S_STREAM;
      S_STREAM:    if (last_hs) state_d = (flag_q || rd_done) ? S_FIN : S_WAIT_DONE;
      S_WAIT_DONE: if (flag_q || rd_done) state_d = S_FIN;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_FIN;
  end

  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    flag_d   = flag_q;
    if (launch) begin
      addr_d   = addr;
      size_d   = size;
      remain_d = size;
      flag_d   = 1'b0;
    end
    if (((state_q == S_REQ) || active) && rd_done) flag_d = 1'b1;
    if (pop) begin
      data_d   = rd_data;
      valid_d  = 1'b1;
      last_d   = (remain_q == SIZE_WIDTH'(1));
      remain_d = remain_q - 1'b1;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    if (timeout_hit) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_FIN);
    rd_go = (state_q == S_REQ);
  end

  assign rd_en   = pop;
  assign rd_addr = addr_q;
  assign rd_size = size_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = last_q;

endmodule

// File: tb/tb_dma_rd_stream.sv
// Bench for dma_rd_stream: a FIFO/controller model feeds words, a scoreboard checks the output stream.
module tb_dma_rd_stream;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, empty, rd_done, m_ready;
  logic [AW-1:0] addr;
  logic [SW-1:0] size;
  logic [DW-1:0] rd_data;
  logic          busy, done, err, rd_go, rd_en, m_valid, m_last;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_size;
  logic [DW-1:0] m_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];

  int n_go, n_pop, n_done, n_stall_pop, n_empty_pop, n_hold_bad, n_err, n_rst_bad, words_got;
  int first_pop, last_pop, first_hs, last_hs_cyc, done_cyc, rd_done_cyc;
  logic [AW-1:0] go_addr;
  logic [SW-1:0] go_size;
  logic err_at_done;
  bit timed_out;

  dma_rd_stream #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .size(size),
    .busy(busy), .done(done), .err(err), .rd_go(rd_go), .rd_addr(rd_addr),
    .rd_size(rd_size), .rd_data(rd_data), .empty(empty), .rd_en(rd_en),
    .rd_done(rd_done), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "bench hung");
  end

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; rd_done = 1'b0; empty = 1'b1; m_ready = 1'b0;
    addr = '0; size = '0; rd_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ready_mode: 0 always, 1 toggling, 2 random. empty_mode: 0 never, 1 random gaps, 2 always.
  // rd_done pulses done_dly cycles after the done_pops-th pop; rst_after>0 resets after that many words.
  task automatic run_xfer(input logic [AW-1:0] a, input int sz, input int ready_mode,
                          input int empty_mode, input int done_pops, input int done_dly,
                          input int rst_after, input int max_cyc);
    logic [DW-1:0] w, exp_w, prev_data;
    logic exp_l, prev_stall, popped;
    bit rst_active;
    int k_cyc, rst_cyc;
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < sz + 3; i++) begin
      w = $urandom;
      src_q.push_back(w);
      if (i < sz) exp_q.push_back(w);
    end
    n_go = 0; n_pop = 0; n_done = 0; n_stall_pop = 0; n_empty_pop = 0; n_hold_bad = 0;
    n_err = 0; n_rst_bad = 0; words_got = 0;
    first_pop = -1; last_pop = -1; first_hs = -1; last_hs_cyc = -1; done_cyc = -1; rd_done_cyc = -1;
    go_addr = '0; go_size = '0; err_at_done = 1'b0; timed_out = 1'b0;
    k_cyc = -1; rst_cyc = -1; rst_active = 1'b0; prev_stall = 1'b0; prev_data = '0;
    start = 1'b1; addr = a; size = sz[SW-1:0];
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      empty   = (src_q.size() == 0) || (empty_mode == 2) || (empty_mode == 1 && $urandom_range(0, 3) == 0);
      rd_data = (src_q.size() != 0) ? src_q[0] : '0;
      m_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ((cyc % 2) != 0) : ($urandom_range(0, 2) != 0);
      rd_done = (k_cyc >= 0) && (cyc == k_cyc + done_dly);
      if (rd_done) rd_done_cyc = cyc;
      @(negedge clk);
      popped = 1'b0;
      if (rst_active) begin
        if ({busy, done, err, rd_go, rd_en, m_valid, m_last} != 7'b0 || rd_addr != '0 ||
            rd_size != '0 || m_data != '0)
          n_rst_bad++;
      end else begin
        if (rd_go) begin n_go++; go_addr = rd_addr; go_size = rd_size; end
        if (rd_en) begin
          popped = 1'b1;
          if (m_valid && !m_ready) n_stall_pop++;
          if (empty) n_empty_pop++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        if (prev_stall && (!m_valid || m_data !== prev_data)) n_hold_bad++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (m_valid && m_ready) begin
          words_got++;
          if (first_hs < 0) first_hs = cyc;
          if (m_last) last_hs_cyc = cyc;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_extra: got word %h, expected no more words", m_data);
          end else begin
            exp_w = exp_q.pop_front();
            exp_l = (exp_q.size() == 0);
            if (m_data !== exp_w || m_last !== exp_l) begin
              tests_failed++;
              $display("FAIL sb_word: got %h last=%b, expected %h last=%b", m_data, m_last, exp_w, exp_l);
            end
          end
        end
        if (done) begin n_done++; if (done_cyc < 0) begin done_cyc = cyc; err_at_done = err; end end
        if (err && cyc >= 1) n_err++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (popped) begin
        void'(src_q.pop_front());
        n_pop++;
        if (n_pop == done_pops) k_cyc = cyc;
      end
      if (rst_after > 0 && !rst_active && words_got == rst_after) begin
        rst_n = 1'b0; rst_active = 1'b1; rst_cyc = cyc;
      end
      if (rst_active && cyc == rst_cyc + 3) rst_n = 1'b1;
      if (rst_active && cyc == rst_cyc + 6) break;
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
    end
    timed_out = (done_cyc < 0) && !rst_active;
    start = 1'b0; rd_done = 1'b0; empty = 1'b1; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rd_done = 1'b0; empty = 1'b1; m_ready = 1'b0;
    addr = '0; size = '0; rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, err, rd_go} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b, expected 0000", {busy, done, err, rd_go});
    end
    tests_run++;
    if ({rd_en, m_valid, m_last} !== 3'b0) begin
      tests_failed++; $display("FAIL reset_stream: got %b, expected 000", {rd_en, m_valid, m_last});
    end
    tests_run++;
    if (rd_addr !== '0 || rd_size !== '0 || m_data !== '0) begin
      tests_failed++; $display("FAIL reset_data: got %h/%h/%h, expected zeros", rd_addr, rd_size, m_data);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_xfer(32'h100, 4, 0, 0, 4, 2, 0, 60);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL basic_timeout: got no done, expected done"); end
    tests_run++;
    if (n_go != 1 || go_addr !== 32'h100 || go_size !== 8'd4) begin
      tests_failed++; $display("FAIL basic_go: got %0d pulses addr %h size %0d, expected 1 pulse addr 100 size 4", n_go, go_addr, go_size);
    end
    tests_run++;
    if (words_got != 4 || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL basic_count: got %0d words, expected 4", words_got);
    end
    tests_run++;
    if (last_pop - first_pop != 3 || last_hs_cyc - first_hs != 3) begin
      tests_failed++; $display("FAIL basic_b2b: got pop span %0d hs span %0d, expected 3 and 3", last_pop - first_pop, last_hs_cyc - first_hs);
    end
    tests_run++;
    if (n_done != 1 || done_cyc != rd_done_cyc + 1) begin
      tests_failed++; $display("FAIL basic_done: got %0d pulses at %0d, expected 1 at %0d", n_done, done_cyc, rd_done_cyc + 1);
    end
  endtask

  task automatic test_stall();
    run_xfer(32'h2000, 3, 1, 0, 3, 1, 0, 60);
    tests_run++;
    if (n_stall_pop != 0) begin tests_failed++; $display("FAIL stall_pop: got %0d pops while stalled, expected 0", n_stall_pop); end
    tests_run++;
    if (n_hold_bad != 0) begin tests_failed++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", n_hold_bad); end
    tests_run++;
    if (words_got != 3 || n_pop != 3 || n_done != 1) begin
      tests_failed++; $display("FAIL stall_count: got %0d words %0d pops %0d done, expected 3 3 1", words_got, n_pop, n_done);
    end
  endtask

  task automatic test_zero_size();
    run_xfer(32'h40, 0, 0, 0, 99, 1, 0, 20);
    tests_run++;
    if (n_go != 0 || n_pop != 0) begin tests_failed++; $display("FAIL zero_req: got %0d go %0d pops, expected 0 0", n_go, n_pop); end
    tests_run++;
    if (n_done != 1 || done_cyc < 1 || done_cyc > 2) begin
      tests_failed++; $display("FAIL zero_done: got %0d pulses at cycle %0d, expected 1 within 2 cycles", n_done, done_cyc);
    end
  endtask

  task automatic test_early_done();
    run_xfer(32'h300, 2, 0, 0, 1, 1, 0, 40);
    tests_run++;
    if (words_got != 2 || n_done != 1 || done_cyc != last_hs_cyc + 1) begin
      tests_failed++; $display("FAIL early_done: got %0d words done at %0d, expected 2 words done at %0d", words_got, done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    run_xfer(32'h400, 8, 0, 0, 8, 2, 2, 60);
    tests_run++;
    if (n_rst_bad != 0) begin tests_failed++; $display("FAIL rstmid_outputs: got %0d nonzero cycles, expected 0", n_rst_bad); end
    tests_run++;
    if (n_done != 0) begin tests_failed++; $display("FAIL rstmid_done: got %0d done pulses, expected 0", n_done); end
  endtask

  task automatic test_max_size();
    run_xfer(32'h800, 255, 0, 0, 255, 1, 0, 400);
    tests_run++;
    if (n_pop != 255 || words_got != 255 || n_done != 1) begin
      tests_failed++; $display("FAIL max_size: got %0d pops %0d words %0d done, expected 255 255 1", n_pop, words_got, n_done);
    end
  endtask

  task automatic test_random();
    int sz;
    logic [AW-1:0] a;
    for (int t = 0; t < 8; t++) begin
      sz = $urandom_range(1, 20);
      a  = $urandom;
      run_xfer(a, sz, 2, 1, sz, $urandom_range(1, 4), 0, 300);
      tests_run++;
      if (n_go != 1 || go_addr !== a || go_size !== sz[SW-1:0]) begin
        tests_failed++; $display("FAIL rand_go: got %0d addr %h size %0d, expected 1 addr %h size %0d", n_go, go_addr, go_size, a, sz);
      end
      tests_run++;
      if (n_pop != sz || words_got != sz || n_done != 1) begin
        tests_failed++; $display("FAIL rand_count: got %0d pops %0d words %0d done, expected %0d %0d 1", n_pop, words_got, n_done, sz, sz);
      end
      tests_run++;
      if (n_stall_pop != 0 || n_hold_bad != 0 || n_empty_pop != 0) begin
        tests_failed++; $display("FAIL rand_flow: got %0d stall pops %0d hold errors %0d empty pops, expected 0", n_stall_pop, n_hold_bad, n_empty_pop);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef DMA_RD_STREAM_TIMEOUT_EN
    run_xfer(32'h500, 4, 0, 2, 99, 1, 0, 60);
    tests_run++;
    if (done_cyc != 18 || err_at_done !== 1'b1 || n_pop != 0) begin
      tests_failed++; $display("FAIL timeout_fire: got done at %0d err %b pops %0d, expected 18 1 0", done_cyc, err_at_done, n_pop);
    end
    run_xfer(32'h600, 2, 0, 0, 2, 1, 0, 40);
    tests_run++;
    if (n_err != 0 || n_done != 1) begin
      tests_failed++; $display("FAIL timeout_clear: got %0d err cycles %0d done, expected 0 1", n_err, n_done);
    end
`else
    run_xfer(32'h500, 4, 0, 2, 99, 1, 0, 40);
    tests_run++;
    if (!timed_out || n_err != 0 || n_done != 0) begin
      tests_failed++; $display("FAIL no_watchdog: got done %0d err cycles %0d, expected no done and err 0", n_done, n_err);
    end
    apply_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_early_done();
    test_reset_mid();
    test_max_size();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
